demux_l_cond: RTL and testbench



---
 rtl/demux_l_cond.sv | 170 +++++++++++++++++
 tb/tb_demux_l_cond.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_l_cond.sv
// demux_l_cond: splits the interleaved fast-clock byte stream back into lane 0
// (even phase) and lane 1 (odd phase). Both lanes are presented together once
// per two-cycle frame with a one-cycle frame_strobe. An alignment FSM locks the
// phase to ALIGN_CHAR so lane assignment does not depend on reset timing.
//
// A comma seen in the lane-1 slot while seeking slips the phase by one slot:
// the slot after the comma is phase 0 and the phase is then held at 0 for one
// more cycle, so the next comma arrives in the lane-0 slot. The frame that was
// in flight when the slip happened is discarded (no strobe, no load).
//
// Optional build macro DEMUX_PAIR_ERR_EN adds pair_err_cnt, a saturating count
// of loads made while locked in which exactly one lane was valid.
module demux_l_cond #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] ALIGN_CHAR = 8'hBC,
  parameter int                    LOCK_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out0,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic                  valid_out1,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  frame_strobe,
  output logic                  locked
`ifdef DEMUX_PAIR_ERR_EN
  ,
  output logic [7:0]            pair_err_cnt
`endif
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);

  localparam logic [0:0] ST_SEEK   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Saturating increment of the lock counter.
  function automatic logic [LCW-1:0] sat_inc_lock(input logic [LCW-1:0] v);
    return (v == LCW'(LOCK_COUNT)) ? v : v + 1'b1;
  endfunction

`ifdef DEMUX_PAIR_ERR_EN
  // Saturating increment of the 8-bit pair error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  logic                  phase_p0;
  logic                  slip_p0;
  logic [0:0]            state_p0;
  logic [LCW-1:0]        lock_cnt_p0;
  logic                  miss_p0;
  logic                  hold0_vld_p0;
  logic [DATA_WIDTH-1:0] hold0_dat_p0;
  logic                  hold1_vld_p0;
  logic [DATA_WIDTH-1:0] hold1_dat_p0;
  logic                  frame_vld_p1;

  logic                  comma;
  logic                  slip;
  logic                  good;
  logic                  miss;
  logic                  drop_lock;
  logic [LCW-1:0]        lock_cnt_nxt;

  assign comma        = valid_in && (data_in == ALIGN_CHAR);
  assign slip         = (state_p0 == ST_SEEK) && comma && phase_p0;
  assign good         = comma && !phase_p0;
  assign miss         = (state_p0 == ST_LOCKED) && comma && phase_p0;
  assign drop_lock    = miss && miss_p0;
  assign lock_cnt_nxt = sat_inc_lock(lock_cnt_p0);
  assign locked       = (state_p0 == ST_LOCKED);

  // Stage p0: phase tracking and slot capture into the per-lane hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_p0     <= 1'b0;
      slip_p0      <= 1'b0;
      hold0_vld_p0 <= 1'b0;
      hold0_dat_p0 <= '0;
      hold1_vld_p0 <= 1'b0;
      hold1_dat_p0 <= '0;
      frame_vld_p1 <= 1'b0;
    end else begin
      phase_p0     <= slip_p0 ? 1'b0 : ~phase_p0;
      slip_p0      <= slip;
      frame_vld_p1 <= phase_p0 && !slip;
      if (!phase_p0) begin
        hold0_vld_p0 <= valid_in;
        if (valid_in) hold0_dat_p0 <= data_in;
      end else begin
        hold1_vld_p0 <= valid_in;
        if (valid_in) hold1_dat_p0 <= data_in;
      end
    end
  end

  // Stage p1: load both lanes together once a complete frame is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_strobe <= 1'b0;
      valid_out0   <= 1'b0;
      data_out0    <= '0;
      valid_out1   <= 1'b0;
      data_out1    <= '0;
    end else begin
      frame_strobe <= frame_vld_p1;
      if (frame_vld_p1) begin
        valid_out0 <= hold0_vld_p0;
        valid_out1 <= hold1_vld_p0;
        if (hold0_vld_p0) data_out0 <= hold0_dat_p0;
        if (hold1_vld_p0) data_out1 <= hold1_dat_p0;
      end
    end
  end

  // Alignment FSM: count well-phased commas to lock, two misses to unlock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0    <= ST_SEEK;
      lock_cnt_p0 <= '0;
      miss_p0     <= 1'b0;
    end else begin
      case (state_p0)
        ST_SEEK: begin
          if (slip) begin
            lock_cnt_p0 <= '0;
          end else if (good) begin
            lock_cnt_p0 <= lock_cnt_nxt;
            miss_p0     <= 1'b0;
            if (lock_cnt_nxt == LCW'(LOCK_COUNT)) state_p0 <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (drop_lock) begin
            state_p0    <= ST_SEEK;
            lock_cnt_p0 <= '0;
            miss_p0     <= 1'b0;
          end else if (miss) begin
            miss_p0 <= 1'b1;
          end else if (good) begin
            miss_p0 <= 1'b0;
          end
        end
        default: begin
          state_p0    <= ST_SEEK;
          lock_cnt_p0 <= '0;
          miss_p0     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_PAIR_ERR_EN
  // Count lopsided loads while locked; cleared when lock is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_err_cnt <= 8'd0;
    end else if (drop_lock) begin
      pair_err_cnt <= 8'd0;
    end else if (frame_vld_p1 && locked && (hold0_vld_p0 != hold1_vld_p0)) begin
      pair_err_cnt <= sat_inc8(pair_err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_demux_l_cond.sv
// Testbench for demux_l_cond: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a frame-level model.
module tb_demux_l_cond;

  localparam int          DW    = 8;
  localparam logic [7:0]  BC    = 8'hBC;
  localparam int          LOCKN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_out0, valid_out1, frame_strobe, locked;
  logic [7:0] data_out0, data_out1;
`ifdef DEMUX_PAIR_ERR_EN
  logic [7:0] pair_err_cnt;
`endif

  always #5 clk = ~clk;

  demux_l_cond #(.DATA_WIDTH(DW), .ALIGN_CHAR(BC), .LOCK_COUNT(LOCKN)) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .data_in(data_in),
    .valid_out0(valid_out0),
    .data_out0(data_out0),
    .valid_out1(valid_out1),
    .data_out1(data_out1),
    .frame_strobe(frame_strobe),
    .locked(locked)
`ifdef DEMUX_PAIR_ERR_EN
    ,
    .pair_err_cnt(pair_err_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: bytes fill lane slots, a completed frame is delivered
  // one cycle later; lock state is tracked with plain counters.
  typedef struct {
    int         due;
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
  } frame_t;

  frame_t     fq[$];
  int         m_cyc = 0, m_pos = 0, m_run = 0, m_miss = 0;
  bit         m_lk = 0, m_rep0 = 0;
  bit         ln_v[2];
  logic [7:0] ln_d[2];
  bit         e_v0 = 0, e_v1 = 0, e_strb = 0, e_lk = 0;
  logic [7:0] e_d0 = 0, e_d1 = 0;
  int         e_err = 0;

  function automatic void model_step(bit r, bit v, logic [7:0] d);
    bit     comma, slipped, was_lk;
    int     slot;
    frame_t f;
    if (r) begin
      fq.delete();
      m_pos = 0; m_run = 0; m_miss = 0; m_lk = 0; m_rep0 = 0;
      e_v0 = 0; e_v1 = 0; e_d0 = 0; e_d1 = 0; e_strb = 0; e_lk = 0; e_err = 0;
      m_cyc++;
      return;
    end
    was_lk = m_lk;
    e_strb = 0;
    if (fq.size() != 0 && fq[0].due == m_cyc) begin
      f = fq.pop_front();
      e_strb = 1;
      e_v0 = f.v0;
      e_v1 = f.v1;
      if (f.v0) e_d0 = f.d0;
      if (f.v1) e_d1 = f.d1;
      if (was_lk && (f.v0 != f.v1) && e_err < 255) e_err++;
    end
    slot = m_pos;
    ln_v[slot] = v;
    ln_d[slot] = d;
    comma = v && (d == BC);
    slipped = 0;
    if (!m_lk) begin
      if (comma && slot == 1) begin
        slipped = 1;
        m_run = 0;
      end else if (comma) begin
        if (m_run < LOCKN) m_run++;
        if (m_run == LOCKN) begin
          m_lk = 1;
          m_miss = 0;
        end
      end
    end else if (comma && slot == 1) begin
      m_miss++;
      if (m_miss == 2) begin
        m_lk = 0; m_run = 0; m_miss = 0; e_err = 0;
      end
    end else if (comma) begin
      m_miss = 0;
    end
    if (slot == 1 && !slipped) fq.push_back('{m_cyc + 1, ln_v[0], ln_v[1], ln_d[0], ln_d[1]});
    if (slipped) begin
      m_pos = 0; m_rep0 = 1;
    end else if (m_rep0) begin
      m_pos = 0; m_rep0 = 0;
    end else begin
      m_pos = 1 - m_pos;
    end
    e_lk = m_lk;
    m_cyc++;
  endfunction

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_out0", valid_out0, e_v0);
      check("valid_out1", valid_out1, e_v1);
      check("data_out0", data_out0, e_d0);
      check("data_out1", data_out1, e_d1);
      check("frame_strobe", frame_strobe, e_strb);
      check("locked", locked, e_lk);
`ifdef DEMUX_PAIR_ERR_EN
      check("pair_err_cnt", pair_err_cnt, e_err);
`endif
    end
  end

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    reset = r; valid_in = v; data_in = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    chk_en = 1'b1;
  endtask

  int         mode = 0;
  bit         rr, rv;
  logic [7:0] rd;

  initial begin
    // Reset held three cycles.
    repeat (3) step(1, 0, 8'h00);
    check("rst_v0", valid_out0, 0);
    check("rst_locked", locked, 0);
    check("rst_strobe", frame_strobe, 0);
    check("rst_d1", data_out1, 8'h00);

    // Idle frames: strobe every second cycle with both lanes invalid.
    step(0, 0, 8'h00); step(0, 0, 8'h00); step(0, 0, 8'h00);
    check("idle_strobe_hi", frame_strobe, 1);
    check("idle_v0", valid_out0, 0);
    step(0, 0, 8'h00);
    check("idle_strobe_lo", frame_strobe, 0);

    // Aligned lock sequence.
    step(0, 1, BC); step(0, 1, 8'h11); step(0, 1, BC); step(0, 1, 8'h22);
    step(0, 1, BC); step(0, 1, 8'h33);
    check("pre_lock", locked, 0);
    step(0, 1, BC);
    check("lock_aligned", locked, 1);
    step(0, 1, 8'h44);
    step(0, 1, 8'hA5);
    check("lock_d0", data_out0, 8'hBC);
    check("lock_d1", data_out1, 8'h44);
    check("lock_strobe", frame_strobe, 1);

    // Partial-valid frame.
    step(0, 0, 8'h5A);
    step(0, 1, 8'h00);
    check("pv_v0", valid_out0, 1);
    check("pv_d0", data_out0, 8'hA5);
    check("pv_v1", valid_out1, 0);
    check("pv_d1_hold", data_out1, 8'h44);
`ifdef DEMUX_PAIR_ERR_EN
    check("pv_err", pair_err_cnt, 1);
`endif

    // Two misphased commas drop lock.
    step(0, 1, BC); step(0, 1, 8'h01);
    check("miss1_locked", locked, 1);
    step(0, 1, BC);
    check("lock_lost", locked, 0);

    // Reacquire.
    step(0, 1, BC); step(0, 1, 8'h61); step(0, 1, BC); step(0, 1, 8'h62);
    step(0, 1, BC); step(0, 1, 8'h63); step(0, 1, BC);
    check("relock", locked, 1);

    // Reset in a phase-1 cycle.
    step(1, 1, 8'h77);
    check("mid_rst_v0", valid_out0, 0);
    check("mid_rst_d0", data_out0, 8'h00);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_strobe", frame_strobe, 0);

    // Late start: comma lands in phase 1 and forces a slip.
    step(0, 0, 8'h00);
    step(0, 1, BC);
    step(0, 1, 8'h11);
    check("slip_suppressed", frame_strobe, 0);
    step(0, 1, BC); step(0, 1, 8'h22); step(0, 1, BC);
    check("slip_d0", data_out0, 8'hBC);
    check("slip_d1", data_out1, 8'h22);
    check("slip_strobe", frame_strobe, 1);
    step(0, 1, 8'h33); step(0, 1, BC); step(0, 1, 8'h44); step(0, 1, BC);
    step(0, 1, 8'h55); step(0, 1, 8'h66);
    check("slip_lock", locked, 1);
    check("slip_lock_d0", data_out0, 8'hBC);
    check("slip_lock_d1", data_out1, 8'h55);

    // Randomized traffic, alternating free-running and comma-aligned bursts.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) mode = 1 - mode;
      rr = ($urandom_range(0, 299) == 0);
      rv = ($urandom_range(0, 7) != 0);
      rd = 8'($urandom);
      if (rd == BC) rd = 8'h00;
      if (mode == 1) begin
        if (m_pos == 0) begin
          if ($urandom_range(0, 9) != 0) rd = BC;
        end else if ($urandom_range(0, 15) == 0) begin
          rd = BC;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rd = BC;
      end
      step(rr, rv, rd);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
